// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM ROM read-port arbiter: channel ID, FSM states, defaults.
package sdram_arb_pkg;

  localparam int NUM_CH_DEF = 6;
  localparam int ADDR_W_DEF = 23;
  localparam int CH_ID_W    = $clog2(NUM_CH_DEF);

  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pend_fifo.sv
// Outstanding-read channel-ID FIFO; head visible with zero latency, push and pop may coincide.
// Push while full and pop while empty are ignored.
module pend_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW:0]   wr_q, wr_d;
  logic [PW:0]   rd_q, rd_d;
  logic          push_ok;
  logic          pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head    = mem_q[rd_q[PW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[PW-1:0]] = push_dat;
      wr_d                = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/sdram_rom_arbiter.sv
// Registered-grant arbiter sharing the SDRAM read port among ROM channels; sdram_req one cycle
// after a request in IDLE, acks/valids combinational. Stalls on hold or full pending FIFO. SDRAM_ARB_AGING_EN adds starvation aging.
module sdram_rom_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PEND_DEPTH = 2,
  parameter int WAIT_W     = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     hold,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     sdram_req,
  output logic [ADDR_W-1:0]        sdram_addr,
  input  logic                     sdram_ack,
  input  logic                     sdram_valid,
  output logic                     busy,
  output logic                     err_orphan
);

  if (MAX_WAIT >= (1 << WAIT_W)) begin : g_bad_wait
    $error("MAX_WAIT must be below 2**WAIT_W");
  end
  if ((PEND_DEPTH < 2) || ((PEND_DEPTH & (PEND_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("PEND_DEPTH must be a power of two and at least 2");
  end

  arb_state_e        state_q, state_d;
  ch_id_t            grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_orphan_q, err_orphan_d;

  logic [ADDR_W-1:0] ch_addr_a [NUM_CH];
  logic [NUM_CH-1:0] cand;
  ch_id_t            win_id;
  logic              start;
  logic              grant_evt;
  logic              fifo_full;
  logic              fifo_empty;
  ch_id_t            fifo_head;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_addr
    assign ch_addr_a[i] = ch_addr[i*ADDR_W +: ADDR_W];
  end

  function automatic ch_id_t lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ch_id_t'(i);
    end
  endfunction

  assign grant_evt = (state_q == ISSUE) && sdram_ack;

`ifdef SDRAM_ARB_AGING_EN
  logic [WAIT_W-1:0] wait_q [NUM_CH];
  logic [WAIT_W-1:0] wait_d [NUM_CH];
  logic [NUM_CH-1:0] starved;

  // Counters move only on grant events: losers that still request age, everyone else clears.
  always_comb begin
    wait_d = wait_q;
    for (int i = 0; i < NUM_CH; i++) begin
      starved[i] = (wait_q[i] == WAIT_W'(MAX_WAIT));
      if (grant_evt) begin
        if (!ch_req[i] || (ch_id_t'(i) == grant_q)) begin
          wait_d[i] = '0;
        end else if (wait_q[i] != WAIT_W'(MAX_WAIT)) begin
          wait_d[i] = wait_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '{default: '0};
    end else begin
      wait_q <= wait_d;
    end
  end

  // A starved flag can outlive its request, so mask with the live request vector.
  assign cand = (|(starved & ch_req)) ? (starved & ch_req) : ch_req;
`else
  assign cand = ch_req;
`endif

  assign win_id = lowest_set(cand);
  assign start  = (state_q == IDLE) && !hold && (|ch_req) && !fifo_full;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    err_orphan_d = err_orphan_q | (sdram_valid & fifo_empty);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          grant_d = win_id;
          addr_d  = ch_addr_a[win_id];
        end
      end
      ISSUE: begin
        if (sdram_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      addr_q       <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  pend_fifo #(
    .DEPTH (PEND_DEPTH),
    .DW    (CH_ID_W)
  ) u_pend_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (grant_evt),
    .push_dat (grant_q),
    .pop      (sdram_valid),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    ch_ack   = '0;
    ch_valid = '0;
    if (grant_evt) ch_ack[grant_q] = 1'b1;
    if (sdram_valid && !fifo_empty) ch_valid[fifo_head] = 1'b1;
  end

  assign sdram_req  = (state_q == ISSUE);
  assign sdram_addr = addr_q;
  assign busy       = (state_q == ISSUE) || !fifo_empty;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Directed bench for sdram_rom_arbiter: vector table for single/priority traffic,
// hand sequences for FIFO backpressure, hold, orphan/reset and aging.
module tb_sdram_rom_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         hold;
  logic [5:0]   ch_req;
  logic [137:0] ch_addr;
  logic [5:0]   ch_ack;
  logic [5:0]   ch_valid;
  logic         sdram_req;
  logic [22:0]  sdram_addr;
  logic         sdram_ack;
  logic         sdram_valid;
  logic         busy;
  logic         err_orphan;

  int tests = 0;
  int fails = 0;

  logic [22:0] ca [6];

  always #5 clk = ~clk;

  sdram_rom_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hold        (hold),
    .ch_req      (ch_req),
    .ch_addr     (ch_addr),
    .ch_ack      (ch_ack),
    .ch_valid    (ch_valid),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .sdram_valid (sdram_valid),
    .busy        (busy),
    .err_orphan  (err_orphan)
  );

  typedef struct {
    logic        hold;
    logic [5:0]  req;
    logic        ack;
    logic        vld;
    logic [5:0]  e_ack;
    logic [5:0]  e_vld;
    logic        e_sreq;
    logic [22:0] e_addr;
    logic        e_busy;
  } vec_t;

  vec_t vt [12];

  function automatic vec_t mk(input logic h, input logic [5:0] r, input logic a, input logic v,
                              input logic [5:0] ea, input logic [5:0] ev, input logic es,
                              input logic [22:0] ead, input logic eb);
    vec_t x;
    x.hold = h; x.req = r; x.ack = a; x.vld = v;
    x.e_ack = ea; x.e_vld = ev; x.e_sreq = es; x.e_addr = ead; x.e_busy = eb;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 2ns later.
  task automatic drive(input logic h, input logic [5:0] r, input logic a, input logic v);
    hold = h; ch_req = r; sdram_ack = a; sdram_valid = v;
    #2;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    hold = 1'b0; ch_req = '0; sdram_ack = 1'b0; sdram_valid = 1'b0;
    reset_n = 1'b0;
    nxt();
    reset_n = 1'b1;
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int exp_ch;
    int ch5_grants;
    logic [5:0] one_hot;

    ca[0] = 23'h000100; ca[1] = 23'h000200; ca[2] = 23'h000300;
    ca[3] = 23'h040010; ca[4] = 23'h123456; ca[5] = 23'h7FFFFF;
    ch_addr = {ca[5], ca[4], ca[3], ca[2], ca[1], ca[0]};

    hold = 1'b0; ch_req = '0; sdram_ack = 1'b0; sdram_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_sreq", 32'(sdram_req), 0);
    chk("rst_addr", 32'(sdram_addr), 0);
    chk("rst_ack", 32'(ch_ack), 0);
    chk("rst_vld", 32'(ch_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_orph", 32'(err_orphan), 0);
    nxt();
    nxt();
    reset_n = 1'b1;
    nxt();

    // Single request on ch3, then ch0/ch4 priority with a simultaneous push/pop.
    vt[0]  = mk(0, 6'h08, 0, 0, 6'h00, 6'h00, 0, 23'h0,      0);
    vt[1]  = mk(0, 6'h08, 0, 0, 6'h00, 6'h00, 1, 23'h040010, 1);
    vt[2]  = mk(0, 6'h08, 1, 0, 6'h08, 6'h00, 1, 23'h040010, 1);
    vt[3]  = mk(0, 6'h00, 0, 0, 6'h00, 6'h00, 0, 23'h0,      1);
    vt[4]  = mk(0, 6'h00, 0, 1, 6'h00, 6'h08, 0, 23'h0,      1);
    vt[5]  = mk(0, 6'h00, 0, 0, 6'h00, 6'h00, 0, 23'h0,      0);
    vt[6]  = mk(0, 6'h11, 0, 0, 6'h00, 6'h00, 0, 23'h0,      0);
    vt[7]  = mk(0, 6'h11, 1, 0, 6'h01, 6'h00, 1, 23'h000100, 1);
    vt[8]  = mk(0, 6'h10, 0, 0, 6'h00, 6'h00, 0, 23'h0,      1);
    vt[9]  = mk(0, 6'h10, 1, 1, 6'h10, 6'h01, 1, 23'h123456, 1);
    vt[10] = mk(0, 6'h00, 0, 1, 6'h00, 6'h10, 0, 23'h0,      1);
    vt[11] = mk(0, 6'h00, 0, 0, 6'h00, 6'h00, 0, 23'h0,      0);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].hold, vt[i].req, vt[i].ack, vt[i].vld);
      chk($sformatf("v%0d_ack", i), 32'(ch_ack), 32'(vt[i].e_ack));
      chk($sformatf("v%0d_vld", i), 32'(ch_valid), 32'(vt[i].e_vld));
      chk($sformatf("v%0d_sreq", i), 32'(sdram_req), 32'(vt[i].e_sreq));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      if (vt[i].e_sreq) chk($sformatf("v%0d_addr", i), 32'(sdram_addr), 32'(vt[i].e_addr));
      nxt();
    end

    // Two outstanding reads fill the FIFO; a third request waits for the first pop.
    drive(0, 6'h02, 0, 0); nxt();
    drive(0, 6'h02, 1, 0); chk("pipe_ack1", 32'(ch_ack), 32'h02); nxt();
    drive(0, 6'h04, 0, 0); nxt();
    drive(0, 6'h04, 1, 0); chk("pipe_ack2", 32'(ch_ack), 32'h04); nxt();
    for (int i = 0; i < 3; i++) begin
      drive(0, 6'h01, 0, 0); chk($sformatf("pipe_full_sreq%0d", i), 32'(sdram_req), 0); nxt();
    end
    drive(0, 6'h01, 0, 1);
    chk("pipe_pop1_vld", 32'(ch_valid), 32'h02);
    chk("pipe_pop1_sreq", 32'(sdram_req), 0);
    nxt();
    drive(0, 6'h01, 0, 0); chk("pipe_unblock_sreq", 32'(sdram_req), 0); nxt();
    drive(0, 6'h01, 0, 0);
    chk("pipe_third_sreq", 32'(sdram_req), 1);
    chk("pipe_third_addr", 32'(sdram_addr), 32'(ca[0]));
    nxt();
    drive(0, 6'h01, 1, 1);
    chk("pipe_ack3", 32'(ch_ack), 32'h01);
    chk("pipe_pop2_vld", 32'(ch_valid), 32'h04);
    nxt();
    drive(0, 6'h00, 0, 1); chk("pipe_pop3_vld", 32'(ch_valid), 32'h01); nxt();
    drive(0, 6'h00, 0, 0);
    chk("pipe_busy", 32'(busy), 0);
    chk("pipe_orph", 32'(err_orphan), 0);
    nxt();

    // Hold raised mid-ISSUE (and the request dropped) does not abort the read.
    drive(0, 6'h04, 0, 0); nxt();
    drive(1, 6'h02, 0, 0);
    chk("hold_sreq", 32'(sdram_req), 1);
    chk("hold_addr", 32'(sdram_addr), 32'(ca[2]));
    nxt();
    drive(1, 6'h02, 1, 0); chk("hold_ack", 32'(ch_ack), 32'h04); nxt();
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'h02, 0, 0); chk($sformatf("hold_blk%0d", i), 32'(sdram_req), 0); nxt();
    end
    drive(0, 6'h02, 0, 0); chk("hold_rel_sreq", 32'(sdram_req), 0); nxt();
    drive(0, 6'h02, 1, 1);
    chk("hold_next_sreq", 32'(sdram_req), 1);
    chk("hold_next_addr", 32'(sdram_addr), 32'(ca[1]));
    chk("hold_next_ack", 32'(ch_ack), 32'h02);
    chk("hold_vld1", 32'(ch_valid), 32'h04);
    nxt();
    drive(0, 6'h00, 0, 1); chk("hold_vld2", 32'(ch_valid), 32'h02); nxt();
    drive(0, 6'h00, 0, 0); chk("hold_busy", 32'(busy), 0); nxt();

    // Orphan valid, then asynchronous reset in the middle of ISSUE.
    drive(0, 6'h00, 0, 1);
    chk("orph_no_vld", 32'(ch_valid), 0);
    chk("orph_not_yet", 32'(err_orphan), 0);
    nxt();
    drive(0, 6'h00, 0, 0); chk("orph_set", 32'(err_orphan), 1); nxt();
    drive(0, 6'h08, 0, 0); nxt();
    drive(0, 6'h08, 0, 0); chk("rst_mid_pre", 32'(sdram_req), 1);
    ch_req = '0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_sreq", 32'(sdram_req), 0);
    chk("rst_mid_orph", 32'(err_orphan), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_addr", 32'(sdram_addr), 0);
    nxt();
    reset_n = 1'b1;
    nxt();
    drive(0, 6'h08, 0, 0); nxt();
    drive(0, 6'h08, 1, 0); chk("forget_ack", 32'(ch_ack), 32'h08); nxt();
    drive(0, 6'h00, 0, 0); chk("forget_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("forget_rst_busy", 32'(busy), 0);
    nxt();
    reset_n = 1'b1;
    nxt();
    drive(0, 6'h00, 0, 1); chk("forget_no_vld", 32'(ch_valid), 0); nxt();
    drive(0, 6'h00, 0, 0); chk("forget_orph", 32'(err_orphan), 1); nxt();
    do_reset();

    // ch0 and ch5 both request continuously for ten grants.
    ch5_grants = 0;
    drive(0, 6'h21, 0, 0); nxt();
    for (int k = 1; k <= 10; k++) begin
`ifdef SDRAM_ARB_AGING_EN
      exp_ch = (k == 9) ? 5 : 0;
`else
      exp_ch = 0;
`endif
      one_hot = 6'h01 << exp_ch;
      drive(0, 6'h21, 1, 0);
      chk($sformatf("age%0d_ack", k), 32'(ch_ack), 32'(one_hot));
      chk($sformatf("age%0d_addr", k), 32'(sdram_addr), 32'(ca[exp_ch]));
      if (ch_ack[5]) ch5_grants++;
      nxt();
      drive(0, 6'h21, 0, 1);
      chk($sformatf("age%0d_vld", k), 32'(ch_valid), 32'(one_hot));
      nxt();
    end
`ifdef SDRAM_ARB_AGING_EN
    chk("age_ch5_grants", 32'(ch5_grants), 1);
`else
    chk("age_ch5_grants", 32'(ch5_grants), 0);
`endif
    drive(0, 6'h00, 1, 0); nxt();
    drive(0, 6'h00, 0, 1); nxt();
    drive(0, 6'h00, 0, 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_orph", 32'(err_orphan), 0);
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
